// File: rtl/seg_scan_if.sv
// Bundle between the value datapath and the 7-segment scan controller:
// display data/load handshake in, anode/segment drive and commit status out.
interface seg_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    enable;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] data_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    blank_lz;
    logic [NUM_DIGITS-1:0]   an;
    logic [7:0]              seg;
    logic                    load_ack;
    logic                    pending;

    modport master (
        output enable, load, data_in, dp_in, blank_lz,
        input  an, seg, load_ack, pending
    );

    modport slave (
        input  enable, load, data_in, dp_in, blank_lz,
        output an, seg, load_ack, pending
    );
endinterface

// File: rtl/seg_scan_controller.sv
// Time-multiplexed common-anode 7-segment scanner with dead-time between digits
// and double-buffered display data that commits only on frame boundaries.
//
// state | meaning
// IDLE  | display dark, waiting for enable
// SHOW  | digit idx lit for REFRESH_DIV cycles
// GAP   | all anodes off for GAP_CYCLES between digit slots
module seg_scan_controller #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GAP_CYCLES  = 2
) (
    input  logic      clk,
    input  logic      reset,
    seg_scan_if.slave bus
);
    localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CMAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0] SHOW_LOAD = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d, idx_next;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d, pend_data_q, pend_data_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d, pend_dp_q, pend_dp_d;
    logic                    pending_q, pending_d;
    logic                    ack_q, ack_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   blank_vec;
    logic                    boundary;
    logic                    lz_run;
    logic [3:0]              nib;

    function automatic logic [6:0] encode(input logic [3:0] v);
        case (v)
            4'h0: encode = 7'b0000001;
            4'h1: encode = 7'b1001111;
            4'h2: encode = 7'b0010010;
            4'h3: encode = 7'b0000110;
            4'h4: encode = 7'b1001100;
            4'h5: encode = 7'b0100100;
            4'h6: encode = 7'b0100000;
            4'h7: encode = 7'b0001111;
            4'h8: encode = 7'b0000000;
            4'h9: encode = 7'b0000100;
            4'hA: encode = 7'b0001000;
            4'hB: encode = 7'b1100000;
            4'hC: encode = 7'b0110001;
            4'hD: encode = 7'b1000010;
            4'hE: encode = 7'b0110000;
            default: encode = 7'b0111000;
        endcase
    endfunction

    always_comb begin
        idx_next = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        boundary = 1'b0;

        // Dropping enable wins over any slot transition and never commits.
        if (!bus.enable) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = SHOW;
                    idx_d    = '0;
                    cnt_d    = SHOW_LOAD;
                    boundary = 1'b1;
                end
                SHOW: begin
                    if (cnt_q == '0) begin
                        if (GAP_CYCLES > 0) begin
                            state_d = GAP;
                            cnt_d   = GAP_LOAD;
                        end else begin
                            idx_d    = idx_next;
                            cnt_d    = SHOW_LOAD;
                            boundary = (idx_next == '0);
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_q == '0) begin
                        state_d  = SHOW;
                        idx_d    = idx_next;
                        cnt_d    = SHOW_LOAD;
                        boundary = (idx_next == '0);
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end

        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        pending_d   = pending_q;
        pend_data_d = pend_data_q;
        pend_dp_d   = pend_dp_q;
        ack_d       = 1'b0;
        if (boundary && pending_q) begin
            shadow_d    = pend_data_q;
            shadow_dp_d = pend_dp_q;
            ack_d       = 1'b1;
            pending_d   = 1'b0;
        end
        // A load on the commit edge re-arms pending for the following frame.
        if (bus.load) begin
            pend_data_d = bus.data_in;
            pend_dp_d   = bus.dp_in;
            pending_d   = 1'b1;
        end

        lz_run    = bus.blank_lz;
        blank_vec = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lz_run       = lz_run & (shadow_d[4*i +: 4] == 4'h0);
            blank_vec[i] = lz_run;
        end

        nib   = shadow_d[4*int'(idx_d) +: 4];
        an_d  = '1;
        seg_d = 8'hFF;
        if (state_d == SHOW) begin
            an_d[idx_d] = 1'b0;
            seg_d = {blank_vec[idx_d] ? 7'h7F : encode(nib), ~shadow_dp_d[idx_d]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            pend_data_q <= '0;
            pend_dp_q   <= '0;
            pending_q   <= 1'b0;
            ack_q       <= 1'b0;
            an_q        <= '1;
            seg_q       <= 8'hFF;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            pend_data_q <= pend_data_d;
            pend_dp_q   <= pend_dp_d;
            pending_q   <= pending_d;
            ack_q       <= ack_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign bus.an       = an_q;
    assign bus.seg      = seg_q;
    assign bus.load_ack = ack_q;
    assign bus.pending  = pending_q;
endmodule

// File: tb/tb_seg_scan_controller.sv
// Bench for seg_scan_controller: frame-position reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_seg_scan_controller;
    localparam int N     = 4;
    localparam int RD    = 4;
    localparam int GAP   = 1;
    localparam int SLOT  = RD + GAP;
    localparam int FRAME = N * SLOT;

    localparam logic [6:0] SEG7 [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seg_scan_if #(.NUM_DIGITS(N)) bus ();

    seg_scan_controller #(
        .NUM_DIGITS (N),
        .REFRESH_DIV(RD),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int vectors = 0;
    int errs    = 0;
    bit chk_en  = 1'b0;

    // Model: position within the frame, counted from the edge that started scanning.
    bit          m_run;
    int          m_p;
    logic [15:0] m_shadow, m_pdata;
    logic [3:0]  m_dp, m_pdp;
    bit          m_pend, m_ack, m_blz;
    bit          m_boundary;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_an();
        logic [3:0] a = 4'hF;
        if (m_run && (m_p % SLOT) < RD) a[m_p / SLOT] = 1'b0;
        return a;
    endfunction

    function automatic logic [7:0] model_seg();
        int slot;
        logic [6:0] s;
        if (!m_run || (m_p % SLOT) >= RD) return 8'hFF;
        slot = m_p / SLOT;
        s = SEG7[m_shadow[4*slot +: 4]];
        if (m_blz && slot != 0 && (m_shadow >> (4*slot)) == 16'h0) s = 7'h7F;
        return {s, ~m_dp[slot]};
    endfunction

    always @(posedge clk) begin
        m_ack      = 1'b0;
        m_boundary = 1'b0;
        if (reset) begin
            m_run = 0; m_p = 0; m_shadow = '0; m_dp = '0;
            m_pend = 0; m_pdata = '0; m_pdp = '0; m_blz = 0;
        end else begin
            if (!bus.enable) begin
                m_run = 0;
            end else if (!m_run) begin
                m_run = 1; m_p = 0; m_boundary = 1;
            end else begin
                m_p = (m_p + 1) % FRAME;
                m_boundary = (m_p == 0);
            end
            if (m_boundary && m_pend) begin
                m_shadow = m_pdata; m_dp = m_pdp; m_ack = 1; m_pend = 0;
            end
            if (bus.load) begin
                m_pdata = bus.data_in; m_pdp = bus.dp_in; m_pend = 1;
            end
            m_blz = bus.blank_lz;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("an", {28'h0, bus.an}, {28'h0, model_an()});
            check("seg", {24'h0, bus.seg}, {24'h0, model_seg()});
            check("load_ack", {31'h0, bus.load_ack}, {31'h0, m_ack});
            check("pending", {31'h0, bus.pending}, {31'h0, m_pend});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_an(input logic [3:0] pat);
        bit ok = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (bus.an === pat) begin ok = 1'b1; break; end
            cyc(1);
        end
        if (!ok) begin
            vectors++; errs++;
            $display("FAIL wait_an timeout: an=%b required %b", bus.an, pat);
        end
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        for (int i = 1; i <= 3 * FRAME; i++) begin
            cyc(1);
            if (bus.load_ack === 1'b1) begin n = i; break; end
        end
        if (n == 0) begin
            vectors++; errs++;
            $display("FAIL wait_ack timeout: no load_ack within %0d cycles", 3 * FRAME);
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp);
        bus.load = 1'b1; bus.data_in = d; bus.dp_in = dp;
        cyc(1);
        bus.load = 1'b0;
    endtask

    int n, acks;
    logic [15:0] rmask;

    initial begin
        reset = 1'b1;
        bus.enable = 1'b0; bus.load = 1'b0; bus.data_in = '0;
        bus.dp_in = '0; bus.blank_lz = 1'b0;
        cyc(2);
        chk_en = 1'b1;
        check("rst_an", {28'h0, bus.an}, 32'hF);
        check("rst_seg", {24'h0, bus.seg}, 32'hFF);
        check("rst_pending", {31'h0, bus.pending}, 32'h0);
        reset = 1'b0;
        cyc(1);

        // Basic scan timing with zero shadow.
        bus.enable = 1'b1;
        cyc(1);
        check("show0_an", {28'h0, bus.an}, 32'hE);
        check("show0_seg", {24'h0, bus.seg}, 32'h03);
        cyc(4);
        check("gap_an", {28'h0, bus.an}, 32'hF);
        check("gap_seg", {24'h0, bus.seg}, 32'hFF);
        cyc(1);
        check("show1_an", {28'h0, bus.an}, 32'hD);

        // Single load commits at the next wrap.
        do_load(16'h12AF, 4'b0001);
        check("pend_set", {31'h0, bus.pending}, 32'h1);
        wait_ack(n);
        check("ack_digit0_an", {28'h0, bus.an}, 32'hE);
        check("digit0_F_dp", {24'h0, bus.seg}, 32'h70);
        wait_an(4'b1101); check("digit1_A", {24'h0, bus.seg}, 32'h11);
        wait_an(4'b1011); check("digit2_2", {24'h0, bus.seg}, 32'h25);
        wait_an(4'b0111); check("digit3_1", {24'h0, bus.seg}, 32'h9F);

        // Repeated loads before a boundary give one ack; latest wins.
        wait_an(4'b1110);
        do_load(16'h1111, 4'b0000);
        do_load(16'h2222, 4'b0000);
        do_load(16'h0009, 4'b0000);
        acks = 0;
        for (int i = 0; i < FRAME + 5; i++) begin
            cyc(1);
            if (bus.load_ack === 1'b1) acks++;
        end
        check("one_ack", acks, 1);
        wait_an(4'b1110); check("show_9", {24'h0, bus.seg}, 32'h09);
        wait_an(4'b0111); check("show_0_unblanked", {24'h0, bus.seg}, 32'h03);

        // Leading-zero blanking.
        bus.blank_lz = 1'b1;
        do_load(16'h0090, 4'b0000);
        wait_ack(n);
        check("lz_d0", {24'h0, bus.seg}, 32'h03);
        wait_an(4'b1101); check("lz_d1", {24'h0, bus.seg}, 32'h09);
        wait_an(4'b1011); check("lz_d2", {24'h0, bus.seg}, 32'hFF);
        wait_an(4'b0111); check("lz_d3", {24'h0, bus.seg}, 32'hFF);
        do_load(16'h0000, 4'b0000);
        wait_ack(n);
        check("lz_all0_d0", {24'h0, bus.seg}, 32'h03);
        wait_an(4'b1101); check("lz_all0_d1", {24'h0, bus.seg}, 32'hFF);
        bus.blank_lz = 1'b0;

        // Load landing on the commit edge.
        do_load(16'h4321, 4'b0000);
        wait_ack(n);
        do_load(16'h0005, 4'b0000);
        cyc(FRAME - 2);
        do_load(16'h0007, 4'b0000);
        check("same_edge_ack", {31'h0, bus.load_ack}, 32'h1);
        check("same_edge_pending", {31'h0, bus.pending}, 32'h1);
        check("same_edge_seg", {24'h0, bus.seg}, 32'h49);
        wait_ack(n);
        check("second_ack_delay", n, FRAME);
        check("second_data", {24'h0, bus.seg}, 32'h1F);

        // Enable drop mid-SHOW of digit 2.
        wait_an(4'b1011);
        cyc(1);
        bus.enable = 1'b0;
        cyc(1);
        check("dis_an", {28'h0, bus.an}, 32'hF);
        check("dis_seg", {24'h0, bus.seg}, 32'hFF);
        cyc(3);
        bus.enable = 1'b1;
        cyc(1);
        check("reen_an", {28'h0, bus.an}, 32'hE);

        // Reset mid-SHOW of digit 2 with a pending load.
        wait_an(4'b1101);
        do_load(16'hBEEF, 4'b1010);
        wait_an(4'b1011);
        reset = 1'b1;
        cyc(1);
        check("mrst_an", {28'h0, bus.an}, 32'hF);
        check("mrst_seg", {24'h0, bus.seg}, 32'hFF);
        check("mrst_pending", {31'h0, bus.pending}, 32'h0);
        check("mrst_ack", {31'h0, bus.load_ack}, 32'h0);
        reset = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bus.enable = ($urandom_range(0, 99) != 0);
            bus.load   = ($urandom_range(0, 15) == 0);
            rmask = {{4{$urandom_range(0, 1) == 1}}, {4{$urandom_range(0, 1) == 1}},
                     {4{$urandom_range(0, 1) == 1}}, {4{$urandom_range(0, 1) == 1}}};
            bus.data_in = 16'($urandom) & rmask;
            bus.dp_in   = 4'($urandom);
            if ($urandom_range(0, 63) == 0) bus.blank_lz = ~bus.blank_lz;
            reset = ($urandom_range(0, 999) == 0);
            cyc(1);
        end
        reset = 1'b0;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
